// File: rtl/addr_range_scanner.sv
// addr_range_scanner: ordered low/high search bounds plus a stride scan engine.
// Define ADDR_RANGE_SCANNER_DESCEND_EN to add the dir port for descending scans.
module addr_range_scanner #(
   parameter int ADDR_W = 5,
   parameter int STRIDE = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] data1,
   input  logic [ADDR_W-1:0] data2,
   input  logic              select1,
   input  logic              select2,
   input  logic              start,
   input  logic              abort,
   input  logic              addr_ready,
`ifdef ADDR_RANGE_SCANNER_DESCEND_EN
   input  logic              dir,
`endif
   output logic [ADDR_W-1:0] addr_out,
   output logic              addr_valid,
   output logic [ADDR_W-1:0] lo_addr,
   output logic [ADDR_W-1:0] hi_addr,
   output logic              same,
   output logic              busy,
   output logic              done
);
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   localparam logic [ADDR_W:0] STEP = (ADDR_W+1)'(STRIDE);
   state_t            state;
   logic [ADDR_W-1:0] reg1, reg2, cur, first;
   logic [ADDR_W:0]   nxt_up, lo_step;
   logic              down, last;
   assign same       = reg1 == reg2;
   assign lo_addr    = reg1 > reg2 ? reg2 : reg1;
   assign hi_addr    = reg1 > reg2 ? reg1 : reg2;
   assign addr_out   = cur;
   assign addr_valid = state == SCAN;
   assign busy       = state == SCAN;
   assign done       = state == DONE;
   // one extra bit keeps the end-of-range test free of wrap-around
   assign nxt_up  = {1'b0, cur} + STEP;
   assign lo_step = {1'b0, lo_addr} + STEP;
   assign last    = down ? ({1'b0, cur} < lo_step) : (nxt_up > {1'b0, hi_addr});
`ifdef ADDR_RANGE_SCANNER_DESCEND_EN
   assign first = dir ? hi_addr : lo_addr;
   always_ff @(posedge clk)
      if (!reset) down <= 1'b0;
      else if (state == IDLE && start) down <= dir;
`else
   assign first = lo_addr;
   assign down  = 1'b0;
`endif
   always_ff @(posedge clk)
      if (!reset) begin
         state <= IDLE;
         reg1  <= '0;
         reg2  <= '0;
         cur   <= '0;
      end else begin
         if (state != SCAN && select1) reg1 <= data1;
         if (state != SCAN && select2) reg2 <= data2;
         case (state)
            IDLE: if (start) begin
               cur   <= first;
               state <= SCAN;
            end
            SCAN: if (abort) state <= IDLE;
            else if (addr_ready) begin
               if (last) state <= DONE;
               else cur <= down ? cur - STEP[ADDR_W-1:0] : nxt_up[ADDR_W-1:0];
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_addr_range_scanner.sv
// tb_addr_range_scanner: scoreboard bench driving a STRIDE=1 and a STRIDE=4 scanner in lockstep.
module tb_addr_range_scanner;
   logic       clk = 0, reset = 0;
   logic [4:0] data1 = 0, data2 = 0;
   logic       select1 = 0, select2 = 0, start = 0, abort = 0, addr_ready = 0, dir = 0;
   logic [4:0] ao[2], lo[2], hi[2];
   logic       av[2], sm[2], bz[2], dn[2];
   int         errors = 0, checks = 0;
   bit         chk_en = 0;
   int         q[2][$];
   bit         exp_done[2], stall[2];
   logic [4:0] prev[2];
   always #5 clk = ~clk;
   addr_range_scanner #(.ADDR_W(5), .STRIDE(1)) u1 (
      .clk(clk), .reset(reset), .data1(data1), .data2(data2), .select1(select1), .select2(select2),
      .start(start), .abort(abort), .addr_ready(addr_ready),
`ifdef ADDR_RANGE_SCANNER_DESCEND_EN
      .dir(dir),
`endif
      .addr_out(ao[0]), .addr_valid(av[0]), .lo_addr(lo[0]), .hi_addr(hi[0]),
      .same(sm[0]), .busy(bz[0]), .done(dn[0]));
   addr_range_scanner #(.ADDR_W(5), .STRIDE(4)) u4 (
      .clk(clk), .reset(reset), .data1(data1), .data2(data2), .select1(select1), .select2(select2),
      .start(start), .abort(abort), .addr_ready(addr_ready),
`ifdef ADDR_RANGE_SCANNER_DESCEND_EN
      .dir(dir),
`endif
      .addr_out(ao[1]), .addr_valid(av[1]), .lo_addr(lo[1]), .hi_addr(hi[1]),
      .same(sm[1]), .busy(bz[1]), .done(dn[1]));
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic load(input logic [4:0] a, input logic [4:0] b);
      data1 = a;
      data2 = b;
      select1 = 1;
      select2 = 1;
      tick;
      select1 = 0;
      select2 = 0;
   endtask
   task automatic start_scan(input int l, input int h, input bit down);
      for (int i = 0; i < 2; i++) begin
         int s;
         s = i ? 4 : 1;
         if (down) for (int x = h; x >= l; x -= s) q[i].push_back(x);
         else for (int x = l; x <= h; x += s) q[i].push_back(x);
      end
      dir = down;
      start = 1;
      tick;
      start = 0;
   endtask
   task automatic wait_idle;
      int n;
      n = 0;
      while ((bz[0] || bz[1] || dn[0] || dn[1]) && n < 200) begin
         tick;
         n++;
      end
      check("idle_timeout", n < 200, 1);
      check("q_left", q[0].size() + q[1].size(), 0);
   endtask
   task automatic wait_addr(input logic [4:0] a);
      int n;
      n = 0;
      while (!(av[0] && ao[0] == a) && n < 50) begin
         tick;
         n++;
      end
      check("addr_wait", ao[0], a);
   endtask
   task automatic check_regs(input string tag, input int l, input int h, input bit s);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check({tag, "_lo"}, lo[i], l);
         check({tag, "_hi"}, hi[i], h);
         check({tag, "_same"}, sm[i], s);
      end
   endtask
   always @(negedge clk)
      if (chk_en)
         for (int i = 0; i < 2; i++) begin
            int e;
            check($sformatf("done%0d", i), dn[i], exp_done[i]);
            check($sformatf("valid_busy%0d", i), av[i], bz[i]);
            if (stall[i]) check($sformatf("hold%0d", i), ao[i], prev[i]);
            exp_done[i] = 0;
            stall[i] = 0;
            if (!reset) q[i].delete();
            else if (av[i] && abort) q[i].delete();
            else if (av[i] && addr_ready) begin
               e = q[i].size() ? q[i].pop_front() : -1;
               check($sformatf("beat%0d", i), ao[i], e);
               exp_done[i] = q[i].size() == 0;
            end else if (av[i]) begin
               stall[i] = 1;
               prev[i] = ao[i];
            end
         end
   initial begin
      repeat (2) tick;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check("rst_valid", av[i], 0);
         check("rst_busy", bz[i], 0);
         check("rst_done", dn[i], 0);
         check("rst_lo", lo[i], 0);
         check("rst_hi", hi[i], 0);
         check("rst_same", sm[i], 1);
      end
      reset = 1;
      chk_en = 1;
      tick;
      load(9, 3);
      check_regs("ord", 3, 9, 0);
      addr_ready = 1;
      start_scan(3, 9, 0);
      wait_idle;
      load(17, 17);
      check_regs("eq", 17, 17, 1);
      start_scan(17, 17, 0);
      wait_idle;
      load(28, 31);
      start_scan(28, 31, 0);
      wait_idle;
      load(31, 2);
      check_regs("wide", 2, 31, 0);
      start_scan(2, 31, 0);
      wait_idle;
      load(0, 5);
      start_scan(0, 5, 0);
      tick;
      addr_ready = 0;
      data1 = 20;
      select1 = 1;
      tick;
      select1 = 0;
      tick;
      addr_ready = 1;
      tick;
      wait_addr(3);
      abort = 1;
      tick;
      abort = 0;
      @(negedge clk);
      check("abort_busy", bz[0], 0);
      check("abort_valid", av[0], 0);
      check("frozen_hi", hi[0], 5);
      check("frozen_lo", lo[0], 0);
      wait_idle;
      start_scan(0, 5, 0);
      wait_addr(4);
      reset = 0;
      tick;
      reset = 1;
      @(negedge clk);
      check("mid_rst_busy", bz[0], 0);
      check("mid_rst_valid", av[0], 0);
      check("mid_rst_done", dn[0], 0);
      check_regs("mid_rst", 0, 0, 1);
      wait_idle;
`ifdef ADDR_RANGE_SCANNER_DESCEND_EN
      load(0, 6);
      start_scan(0, 6, 1);
      wait_idle;
      dir = 0;
`endif
      repeat (3) tick;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
